uart_pkt_rx: RTL and testbench

UART_PKT_RX -- requirements
Module: uart_pkt_rx

---
 rtl/uart_pkt_pkg.sv | 22 ++
 rtl/uart_pkt_buf.sv | 35 +++
 rtl/uart_pkt_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_pkt_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receiver.
// Contents:
//   state_t            - receiver FSM states
//   ERR_LEN/CHK/TMO    - err_code values reported with frame_err
//   SYNC_BYTE_DEFAULT  - default frame start marker
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store for one frame: MAX_LEN bytes of registers.
// Ports:
//   clk      - system clock
//   wr_en    - write wr_data at wr_idx on the rising edge
//   wr_idx   - write index (0..MAX_LEN-1)
//   wr_data  - byte to store
//   rd_idx   - read index (0..MAX_LEN-1)
//   rd_data  - combinational read of the byte at rd_idx
module uart_pkt_buf #(
    parameter int DATA_BITS = 8,
    parameter int MAX_LEN   = 16
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_idx,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [DATA_BITS-1:0] rd_idx,
    output logic [DATA_BITS-1:0] rd_data
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [DATA_BITS-1:0] DEPTH = DATA_BITS'(MAX_LEN);

    logic [DATA_BITS-1:0] mem [MAX_LEN];

    // Out-of-range indices are ignored on write and read back as zero.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_idx < DEPTH)) begin
            mem[wr_idx[IW-1:0]] <= wr_data;
        end
    end

    assign rd_data = (rd_idx < DEPTH) ? mem[rd_idx[IW-1:0]] : '0;

endmodule

// File: rtl/uart_pkt_rx.sv
// Framed packet receiver behind a first-word-fall-through UART RX FIFO.
// Frame: SYNC_BYTE, LEN, LEN payload bytes, CHK (XOR of LEN and payload).
// A good frame is buffered, then streamed out with valid/ready handshaking.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   rx_data, rx_empty   - FIFO head byte and empty flag
//   rd_en               - pops the FIFO head this cycle
//   pkt_data/valid/last - payload stream out, pkt_ready accepts a byte
//   frame_ok, frame_err - one-cycle frame result pulses
//   err_code            - cause of the latest frame_err (held)
//   err_cnt             - saturating count of frame_err pulses
module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter int         DATA_BITS      = 8,
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_empty,
    output logic                 rd_en,
    output logic [DATA_BITS-1:0] pkt_data,
    output logic                 pkt_valid,
    output logic                 pkt_last,
    input  logic                 pkt_ready,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic [15:0]          err_cnt
);

    localparam logic [DATA_BITS-1:0] MAX_LEN_W = DATA_BITS'(MAX_LEN);
    localparam logic [DATA_BITS-1:0] ONE_W     = DATA_BITS'(1);
    localparam logic [31:0]          TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] len_q, wr_idx, rd_idx, xor_q, buf_rdata;
    logic [31:0]          gap_cnt;
    logic [1:0]           err_n;
    logic                 consume, in_frame, timeout, last_byte, buf_we;

    // Every outward-facing strobe is masked while reset is held so that a
    // reset arriving mid-frame never pops the FIFO or reports an error.
    assign in_frame  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign consume   = !reset && !rx_empty && (state != ST_DRAIN);
    assign rd_en     = consume;
    assign timeout   = !consume && in_frame && (gap_cnt == TMO_LIMIT);
    assign last_byte = (rd_idx == (len_q - ONE_W));

    uart_pkt_buf #(
        .DATA_BITS (DATA_BITS),
        .MAX_LEN   (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (wr_idx),
        .wr_data (rx_data),
        .rd_idx  (rd_idx),
        .rd_data (buf_rdata)
    );

    // Next-state and output decode. A byte consumed in the same cycle as
    // the timeout threshold is handled normally; timeout only fires idle.
    always_comb begin
        state_n   = state;
        buf_we    = 1'b0;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        err_n     = err_code;
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        pkt_data  = '0;
        if (!reset) begin
            case (state)
                ST_HUNT: begin
                    if (consume && (rx_data == SYNC_BYTE)) state_n = ST_LEN;
                end
                ST_LEN: begin
                    if (consume) begin
                        if ((rx_data == '0) || (rx_data > MAX_LEN_W)) begin
                            frame_err = 1'b1;
                            err_n     = ERR_LEN;
                            state_n   = ST_HUNT;
                        end else begin
                            state_n = ST_PAYLOAD;
                        end
                    end else if (timeout) begin
                        frame_err = 1'b1;
                        err_n     = ERR_TMO;
                        state_n   = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    if (consume) begin
                        buf_we = 1'b1;
                        if (wr_idx == (len_q - ONE_W)) state_n = ST_CHK;
                    end else if (timeout) begin
                        frame_err = 1'b1;
                        err_n     = ERR_TMO;
                        state_n   = ST_HUNT;
                    end
                end
                ST_CHK: begin
                    if (consume) begin
                        if (rx_data == xor_q) begin
                            state_n = ST_DRAIN;
                        end else begin
                            frame_err = 1'b1;
                            err_n     = ERR_CHK;
                            state_n   = ST_HUNT;
                        end
                    end else if (timeout) begin
                        frame_err = 1'b1;
                        err_n     = ERR_TMO;
                        state_n   = ST_HUNT;
                    end
                end
                ST_DRAIN: begin
                    pkt_valid = 1'b1;
                    pkt_data  = buf_rdata;
                    pkt_last  = last_byte;
                    if (pkt_ready && last_byte) begin
                        frame_ok = 1'b1;
                        state_n  = ST_HUNT;
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end
    end

    // State, indices, running XOR, gap counter and error bookkeeping.
    // The gap counter sits at zero outside a frame, so entry to LEN
    // always starts the inter-byte timer from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_HUNT;
            len_q    <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            xor_q    <= '0;
            gap_cnt  <= '0;
            err_code <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_n;

            if (frame_err) begin
                err_code <= err_n;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end

            if (in_frame && !consume && !timeout) gap_cnt <= gap_cnt + 32'd1;
            else                                  gap_cnt <= '0;

            case (state)
                ST_HUNT: begin
                    wr_idx <= '0;
                    rd_idx <= '0;
                end
                ST_LEN: begin
                    if (consume) begin
                        len_q <= rx_data;
                        xor_q <= rx_data;
                    end
                end
                ST_PAYLOAD: begin
                    if (consume) begin
                        xor_q  <= xor_q ^ rx_data;
                        wr_idx <= wr_idx + ONE_W;
                    end
                end
                ST_DRAIN: begin
                    if (pkt_ready) rd_idx <= rd_idx + ONE_W;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Scoreboard bench for uart_pkt_rx. A behavioural FIFO feeds directed
// byte streams; expected payload bytes and frame results are queued when
// stimulus is issued and a monitor pops and compares them as the DUT
// produces them.
module tb_uart_pkt_rx;
    import uart_pkt_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } pkt_t;

    logic        clk, reset, rx_empty, rd_en, pkt_valid, pkt_last, pkt_ready;
    logic        frame_ok, frame_err;
    logic [7:0]  rx_data, pkt_data;
    logic [1:0]  err_code;
    logic [15:0] err_cnt;

    logic [7:0]  fifo[$];
    pkt_t        exp_pkt[$];
    int          exp_evt[$];
    logic        pop_pending;
    int          acc_cnt;
    int          tests_run;
    int          tests_failed;

    uart_pkt_rx #(
        .DATA_BITS      (8),
        .MAX_LEN        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rd_en     (rd_en),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_last  (pkt_last),
        .pkt_ready (pkt_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s", name);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic expectPkt(input logic [7:0] d, input logic l);
        pkt_t p;
        p.data = d;
        p.last = l;
        exp_pkt.push_back(p);
    endtask

    // Event code 0 means frame_ok, otherwise the err_code expected with frame_err.
    task automatic expectEvt(input int code);
        exp_evt.push_back(code);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while ((fifo.size() != 0 || exp_pkt.size() != 0 || exp_evt.size() != 0 || pkt_valid)
               && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) reportFail({name, "_idle_timeout"});
        repeat (3) @(posedge clk);
        #1;
    endtask

    // FIFO model: rd_en observed at the falling edge pops the head at the rising edge.
    initial begin
        rx_empty    = 1'b1;
        rx_data     = 8'h00;
        pop_pending = 1'b0;
        forever begin
            logic take;
            @(posedge clk);
            take = pop_pending;
            #1;
            if (take && fifo.size() > 0) void'(fifo.pop_front());
            rx_empty = (fifo.size() == 0);
            rx_data  = rx_empty ? 8'h00 : fifo[0];
        end
    end

    initial forever begin
        @(negedge clk);
        pop_pending = rd_en;
    end

    // Monitor: compares every handshake, stall and frame result to the queues.
    initial begin
        acc_cnt = 0;
        forever begin
            @(negedge clk);
            if (pkt_valid && pkt_ready) begin
                if (exp_pkt.size() == 0) begin
                    reportFail("unexpected_pkt");
                end else begin
                    pkt_t e;
                    e = exp_pkt.pop_front();
                    checkOutput("pkt_data", 32'(pkt_data), 32'(e.data));
                    checkOutput("pkt_last", 32'(pkt_last), 32'(e.last));
                    acc_cnt++;
                end
            end else if (pkt_valid && !pkt_ready && exp_pkt.size() > 0) begin
                checkOutput("stall_data", 32'(pkt_data), 32'(exp_pkt[0].data));
                checkOutput("stall_last", 32'(pkt_last), 32'(exp_pkt[0].last));
            end
            if (frame_ok && frame_err) reportFail("ok_and_err_together");
            if (frame_ok) begin
                if (exp_evt.size() == 0) reportFail("unexpected_frame_ok");
                else checkOutput("frame_ok_evt", 32'd0, 32'(exp_evt.pop_front()));
            end else if (frame_err) begin
                if (exp_evt.size() == 0) begin
                    reportFail("unexpected_frame_err");
                end else begin
                    int ev;
                    ev = exp_evt.pop_front();
                    @(posedge clk); #1;
                    checkOutput("err_code", 32'(err_code), 32'(ev));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests_run + 1, tests_failed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int target;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        pkt_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rd_en",     32'(rd_en),     32'd0);
        checkOutput("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        checkOutput("rst_pkt_last",  32'(pkt_last),  32'd0);
        checkOutput("rst_pkt_data",  32'(pkt_data),  32'h00);
        checkOutput("rst_frame_ok",  32'(frame_ok),  32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst_err_code",  32'(err_code),  32'd0);
        checkOutput("rst_err_cnt",   32'(err_cnt),   32'd0);
        checkOutput("rst_state",     32'(dut.state), 32'(ST_HUNT));
        reset = 1'b0;

        // Good 3-byte frame: 03^11^22^33 = 03.
        applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
        applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h03);
        expectPkt(8'h11, 1'b0); expectPkt(8'h22, 1'b0); expectPkt(8'h33, 1'b1);
        expectEvt(0);
        waitIdle(200, "good3");
        checkOutput("good3_err_cnt", 32'(err_cnt), 32'd0);

        // Same frame with a bad checksum.
        applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
        applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h04);
        expectEvt(2);
        waitIdle(200, "badchk");
        checkOutput("badchk_err_cnt", 32'(err_cnt), 32'd1);

        // Leading junk, then a single-byte frame: 01^7E = 7F.
        applyStimulus(8'h00); applyStimulus(8'hFF); applyStimulus(8'hA5);
        applyStimulus(8'h01); applyStimulus(8'h7E); applyStimulus(8'h7F);
        expectPkt(8'h7E, 1'b1);
        expectEvt(0);
        waitIdle(200, "junk");
        checkOutput("junk_err_cnt", 32'(err_cnt), 32'd1);

        // LEN 0 and LEN 17 rejected, then 01^55 = 54.
        applyStimulus(8'hA5); applyStimulus(8'h00);
        applyStimulus(8'hA5); applyStimulus(8'h11);
        applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h55); applyStimulus(8'h54);
        expectEvt(1); expectEvt(1);
        expectPkt(8'h55, 1'b1);
        expectEvt(0);
        waitIdle(200, "badlen");
        checkOutput("badlen_err_cnt", 32'(err_cnt), 32'd3);

        // Stalled frame times out; the following frame 02^AB^CD = 64 is delivered.
        applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h10);
        expectEvt(3);
        waitIdle(3000, "timeout");
        checkOutput("timeout_err_cnt", 32'(err_cnt), 32'd4);
        applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'hAB);
        applyStimulus(8'hCD); applyStimulus(8'h64);
        expectPkt(8'hAB, 1'b0); expectPkt(8'hCD, 1'b1);
        expectEvt(0);
        waitIdle(200, "after_tmo");
        checkOutput("err_code_held", 32'(err_code), 32'd3);
        checkOutput("after_tmo_err_cnt", 32'(err_cnt), 32'd4);

        // 16-byte frame 01..10: XOR of 01..10 is 10, with LEN 10 gives CHK 00.
        // pkt_ready toggles; reset lands after the eighth accepted byte.
        applyStimulus(8'hA5); applyStimulus(8'h10);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(8'(i));
            expectPkt(8'(i), (i == 16));
        end
        applyStimulus(8'h00);
        target = acc_cnt + 8;
        begin
            int n = 0;
            while (acc_cnt < target && n < 2000) begin
                @(posedge clk); #1;
                if (acc_cnt >= target) break;
                pkt_ready = ~pkt_ready;
                n++;
            end
            if (n >= 2000) reportFail("stall_drain_timeout");
        end
        reset = 1'b1;
        exp_pkt.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        pkt_ready = 1'b1;
        checkOutput("midrst_pkt_valid", 32'(pkt_valid), 32'd0);
        checkOutput("midrst_state",     32'(dut.state), 32'(ST_HUNT));
        checkOutput("midrst_err_cnt",   32'(err_cnt),   32'd0);
        checkOutput("midrst_err_code",  32'(err_code),  32'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("post_rst_pkt_valid", 32'(pkt_valid), 32'd0);
        if (exp_evt.size() != 0) reportFail("leftover_events");
        if (exp_pkt.size() != 0) reportFail("leftover_pkts");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
